// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
// The result commits atomically on the last busy cycle, so partial values never appear on HI/LO.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;

    logic        issue, last;
    logic        mul_sgn, div_sgn, a_neg, b_neg;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] mag_a, mag_b, quo_u, rem_u, quo, rem;

    assign issue = (state_q == IDLE) && start && (op[2] == 1'b0);
    assign last  = (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue) state_d = BUSY;
            BUSY: if (last)  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
        HI   = hi_q;
        LO   = lo_q;
    end

    // One shared multiplier; sign-extension to 64 bits selects signed vs unsigned
    always_comb begin
        mul_sgn = (op_q == OP_MULT);
        mul_a   = {{32{mul_sgn & a_q[31]}}, a_q};
        mul_b   = {{32{mul_sgn & b_q[31]}}, b_q};
        prod    = mul_a * mul_b;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0
    always_comb begin
        div_sgn = (op_q == OP_DIV);
        a_neg   = div_sgn & a_q[31];
        b_neg   = div_sgn & b_q[31];
        mag_a   = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b   = b_neg ? (~b_q + 32'd1) : b_q;
        quo_u   = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
        rem_u   = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
        quo     = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
        rem     = a_neg ? (~rem_u + 32'd1) : rem_u;
    end

    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    op_d  = op;
                    a_d   = A;
                    b_d   = B;
                    cnt_d = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                end else if (start && op == OP_MTHI) begin
                    hi_d = A;
                end else if (start && op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (last) begin
                    cnt_d = '0;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        {hi_d, lo_d} = prod;
                    end else if ((op_q == OP_DIV || op_q == OP_DIVU) && b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
        endcase
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL be parameterised as follows.
- MULT_CYCLES, default 5, cycles busy is high for MULT/MULTU.
- DIV_CYCLES, default 10, cycles busy is high for DIV/DIVU.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be as follows (clock and reset first).
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous active-high reset.
- start  input  1  issue request, sampled at posedge.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved.
- A  input  32  operand 1 (rs value, already forwarded).
- B  input  32  operand 2 (rt value, already forwarded).
- busy  output  1  multi-cycle operation in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Function
REQ-004 The state machine SHALL have two states, IDLE and BUSY; busy SHALL be 1 exactly when the state is BUSY.
REQ-005 In IDLE, start=1 with op 0–3 at edge N SHALL do three things.
- Latch A, B and op.
- Load the down-counter with MULT_CYCLES (op 0–1) or DIV_CYCLES (op 2–3).
- Enter BUSY, so busy=1 after edge N.
REQ-006 In BUSY, each edge SHALL decrement the counter; at the edge where the counter equals 1, the block SHALL commit the result to HI/LO and return to IDLE.
- MULT/MULTU: busy is therefore high for exactly MULT_CYCLES cycles.
- DIV/DIVU: busy is therefore high for exactly DIV_CYCLES cycles.
REQ-007 HI/LO SHALL hold their previous values throughout BUSY; intermediate results SHALL never be visible.
REQ-008 MULT SHALL compute the signed 32x32 product; MULTU SHALL compute the unsigned product. In both cases {HI,LO} = 64-bit product.
REQ-009 DIV and DIVU SHALL compute LO = quotient and HI = remainder.
- DIV is signed; the quotient truncates toward zero and the remainder takes the sign of the dividend.
- DIVU is unsigned.
REQ-010 For DIV with A=0x80000000 and B=0xFFFFFFFF, the result SHALL be LO=0x80000000 and HI=0x00000000.
REQ-011 For DIV/DIVU with B=0, the block SHALL run the full DIV_CYCLES busy period and then leave HI/LO unchanged.
REQ-012 In IDLE, start=1 with op 4 (MTHI) SHALL write HI=A, and op 5 (MTLO) SHALL write LO=A, at that same edge; busy SHALL stay 0.
REQ-013 start=1 with op 6–7 SHALL be ignored with no state change.
REQ-014 Any start while in BUSY (including MTHI/MTLO) SHALL be ignored; upstream stall logic is responsible for holding such instructions.
REQ-015 Operands SHALL be taken only from the latch made at issue; changes on A/B/op during BUSY SHALL NOT affect the result.
REQ-016 A start in the cycle immediately after busy falls SHALL be accepted normally, giving back-to-back operation with no dead cycle.
REQ-017 The outputs SHALL be registered: busy, HI and LO SHALL depend only on state, never combinationally on the inputs.

Reset
REQ-018 reset=1 at a posedge SHALL force state IDLE, busy=0, HI=0, LO=0 and counter=0, overriding start.
REQ-019 reset during BUSY SHALL cancel the operation; no commit SHALL occur afterwards.

Verification
REQ-020 MULT, A=0xFFFFFFFF, B=2 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-021 DIV, A=0xFFFFFFF9, B=2 -> busy high exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=7, B=2 -> LO=3, HI=1.
REQ-022 Preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV with B=0 -> busy high 10 cycles; HI=0x11, LO=0x22 afterwards.
REQ-023 Start MULT 3x4; on the 2nd busy cycle pulse start with MTLO A=0x1234 -> MTLO ignored; final HI=0, LO=0x0000000C.
REQ-024 Start DIV 100/7; assert reset on the 3rd busy cycle -> next cycle busy=0, HI=LO=0, and they stay 0 for 10 more cycles.
REQ-025 MTHI A=0xDEADBEEF in IDLE -> HI=0xDEADBEEF after one edge, busy never rises; then MULTU 2x3 is issued the cycle after busy falls from a prior op -> accepted, LO=6.
